// File: rtl/fpu_pkg.sv
// Shared FPU definitions: operator codes, IEEE-754 single field widths and the unpacked operand form.
package fpu_pkg;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_MUL  = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

    localparam int BIAS      = 127;
    localparam int MAX_SHIFT = 25;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int MANT_W = 24;
    localparam int PROD_W = 48;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
    } fpu_unpacked_t;

endpackage

// File: rtl/fpu_unpack.sv
// Combinational split of an IEEE-754 single into sign, effective exponent and 24-bit mantissa.
// Subnormals flush to zero unless FPU_ALIGN_DENORM_EN is defined.
module fpu_unpack
    import fpu_pkg::*;
(
    input  logic [31:0]   fp_i,
    output fpu_unpacked_t u_o,
    output logic          zero_o
);

    logic [EXP_W-1:0]  exp_f;
    logic [FRAC_W-1:0] frac_f;

    assign exp_f  = fp_i[30:23];
    assign frac_f = fp_i[22:0];

    always_comb begin
        u_o.sign = fp_i[31];
        if (exp_f == '0) begin
`ifdef FPU_ALIGN_DENORM_EN
            u_o.exp  = 8'd1;
            u_o.mant = {1'b0, frac_f};
`else
            u_o.exp  = '0;
            u_o.mant = '0;
`endif
        end else begin
            u_o.exp  = exp_f;
            u_o.mant = {1'b1, frac_f};
        end
    end

    assign zero_o = (u_o.mant == '0);

endmodule

// File: rtl/fpu_align.sv
// FPU front end (2-stage valid/ready pipe): unpack, order/align, raw add/sub/mul; FPU_ALIGN_DENORM_EN keeps subnormals.
// Latency 2 cycles, 1 result/cycle; a stalled output holds both stages and drops in_ready.
module fpu_align
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [1:0]  op,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sign,
    output logic [7:0]  out_exponent,
    output logic [47:0] out_mantissa,
    output logic [1:0]  out_operator
);

    fpu_unpacked_t ua, ub, ul, us;
    logic          za, zb;

    fpu_unpack u_unpack_a (.fp_i(a), .u_o(ua), .zero_o(za));
    fpu_unpack u_unpack_b (.fp_i(b), .u_o(ub), .zero_o(zb));

    logic s2_en, s1_en;
    logic s1_valid_q, s1_valid_d;
    logic s2_valid_q, s2_valid_d;

    assign s2_en    = !s2_valid_q || out_ready;
    assign s1_en    = !s1_valid_q || s2_en;
    assign in_ready = s1_en;

    // ---------------- stage 1: order, align, exponent sum ----------------
    logic               sb_eff, sl, ss, a_ge_b;
    logic [EXP_W-1:0]   diff;
    logic [MANT_W-1:0]  ms_sh;
    logic signed [9:0]  msum;

    logic               s1_sign_d, s1_effsub_d, s1_zero_d;
    logic signed [9:0]  s1_exp_d;
    logic [MANT_W-1:0]  s1_ma_d, s1_mb_d;

    logic               s1_sign_q, s1_effsub_q, s1_zero_q;
    logic signed [9:0]  s1_exp_q;
    logic [MANT_W-1:0]  s1_ma_q, s1_mb_q;
    logic [1:0]         s1_op_q;

    always_comb begin
        sb_eff = ub.sign ^ (op == OP_SUB);
        a_ge_b = {ua.exp, ua.mant} >= {ub.exp, ub.mant};
        if (a_ge_b) begin
            ul = ua;
            us = ub;
            sl = ua.sign;
            ss = sb_eff;
        end else begin
            ul = ub;
            us = ua;
            sl = sb_eff;
            ss = ua.sign;
        end
        diff  = ul.exp - us.exp;
        ms_sh = (diff >= 8'(MAX_SHIFT)) ? '0 : (us.mant >> diff);
        msum  = $signed({2'b00, ua.exp}) + $signed({2'b00, ub.exp}) - 10'sd127;

        if (op == OP_MUL) begin
            s1_sign_d   = ua.sign ^ ub.sign;
            s1_exp_d    = msum;
            s1_ma_d     = ua.mant;
            s1_mb_d     = ub.mant;
            s1_effsub_d = 1'b0;
            s1_zero_d   = za || zb;
        end else begin
            s1_sign_d   = sl;
            s1_exp_d    = $signed({2'b00, ul.exp});
            s1_ma_d     = ul.mant;
            s1_mb_d     = ms_sh;
            s1_effsub_d = sl ^ ss;
            s1_zero_d   = 1'b0;
        end
    end

    assign s1_valid_d = s1_en ? in_valid : s1_valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_exp_q    <= '0;
            s1_ma_q     <= '0;
            s1_mb_q     <= '0;
            s1_effsub_q <= 1'b0;
            s1_zero_q   <= 1'b0;
            s1_op_q     <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            if (s1_en && in_valid) begin
                s1_sign_q   <= s1_sign_d;
                s1_exp_q    <= s1_exp_d;
                s1_ma_q     <= s1_ma_d;
                s1_mb_q     <= s1_mb_d;
                s1_effsub_q <= s1_effsub_d;
                s1_zero_q   <= s1_zero_d;
                s1_op_q     <= op;
            end
        end
    end

    // ---------------- stage 2: raw arithmetic ----------------
    logic [PROD_W-1:0]  prod;
    logic [MANT_W:0]    addsub;
    logic               s2_sign_d, s2_sign_q;
    logic [EXP_W-1:0]   s2_exp_d, s2_exp_q;
    logic [PROD_W-1:0]  s2_mant_d, s2_mant_q;
    logic [1:0]         s2_op_q;

    assign prod   = {24'b0, s1_ma_q} * {24'b0, s1_mb_q};
    assign addsub = s1_effsub_q ? ({1'b0, s1_ma_q} - {1'b0, s1_mb_q})
                                : ({1'b0, s1_ma_q} + {1'b0, s1_mb_q});

    always_comb begin
        s2_sign_d = 1'b0;
        s2_exp_d  = '0;
        s2_mant_d = '0;
        case (s1_op_q)
            OP_ADD, OP_SUB: begin
                if (addsub != '0) begin
                    s2_sign_d = s1_sign_q;
                    s2_exp_d  = s1_exp_q[7:0];
                    s2_mant_d = {23'b0, addsub};
                end
            end
            OP_MUL: begin
                s2_sign_d = s1_sign_q;
                if (!s1_zero_q && s1_exp_q >= 10'sd1) begin
                    s2_exp_d  = (s1_exp_q > 10'sd254) ? 8'd254 : s1_exp_q[7:0];
                    s2_mant_d = prod;
                end
            end
            default: begin
            end
        endcase
    end

    assign s2_valid_d = s2_en ? s1_valid_q : s2_valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            s2_sign_q  <= 1'b0;
            s2_exp_q   <= '0;
            s2_mant_q  <= '0;
            s2_op_q    <= '0;
        end else begin
            s2_valid_q <= s2_valid_d;
            if (s2_en && s1_valid_q) begin
                s2_sign_q <= s2_sign_d;
                s2_exp_q  <= s2_exp_d;
                s2_mant_q <= s2_mant_d;
                s2_op_q   <= s1_op_q;
            end
        end
    end

    assign out_valid    = s2_valid_q;
    assign out_sign     = s2_sign_q;
    assign out_exponent = s2_exp_q;
    assign out_mantissa = s2_mant_q;
    assign out_operator = s2_op_q;

endmodule

// File: doc/fpu_align.md
Name: fpu_align

Overview:
Front-end arithmetic stage of the FPU that feeds fpu_normalize. It accepts two packed IEEE-754 single operands plus an operator, then unpacks, compares, aligns and computes the raw result. It emits un-normalized sign, exponent and 48-bit mantissa in exactly the format the normalize stage consumes. It is a 2-stage elastic pipeline with valid/ready handshakes on both sides.

Parameters:
BIAS, 127, exponent bias used for the multiply exponent.
MAX_SHIFT, 25, alignment distance at or above which the smaller mantissa becomes 0.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  operand pair valid
in_ready  out  1  stage 1 can accept
a  in  32  operand A, IEEE-754 single
b  in  32  operand B, IEEE-754 single
op  in  2  00 add, 01 sub, 10 mul, 11 reserved
out_valid  out  1  result valid
out_ready  in  1  downstream accepts
out_sign  out  1  result sign
out_exponent  out  8  un-normalized exponent
out_mantissa  out  48  raw mantissa
out_operator  out  2  op passed through

Behaviour:
- Reset: clk single clock; rst asynchronous, active-high.
- While rst is high: both stage valids = 0, out_valid = 0, out_sign = 0, out_exponent = 0, out_mantissa = 0, out_operator = 0.
- in_ready is high out of reset.
- Handshake:
  - Transfer occurs when valid && ready.
  - Stage N advances when it is empty or its contents are consumed in the same cycle.
  - in_ready = !s1_valid || s1_advance.
  - Latency is 2 cycles from input accept to out_valid with no stalls. Full throughput is 1 result per cycle.
  - Outputs hold stable while out_valid && !out_ready.
  - Results leave in order; no drops, no duplicates.
- Stage 1 (register):
  - Unpack fields. Exponent 0 flushes to zero: implicit bit 0, mantissa forced 0.
  - Exponent 255 is treated as a normal value; there is no inf/NaN handling.
  - For sub, invert B's sign.
  - For add/sub, order by {exp,frac}. The larger operand becomes L and carries the exponent and sign.
  - The smaller 24-bit mantissa is shifted right by (eL - eS), truncated. A shift of MAX_SHIFT or more gives 0.
  - For mul, register both 24-bit mantissas, sign = sa^sb, and a 10-bit signed exponent sum ea+eb-BIAS.
- Stage 2 (register, drives outputs):
  - Add/sub: effective add gives mL+mS; effective subtract gives mL-mS. The result sits in mantissa[24:0]; bits [47:25] = 0. Exponent = eL.
  - Add/sub exact zero result: sign 0, exponent 0, mantissa 0.
  - Mul: mantissa = mA*mB (48 bits).
  - Mul with either operand zero, or exponent sum < 1: sign = sa^sb, exponent 0, mantissa 0.
  - Mul with exponent sum > 254: exponent saturates to 254.
  - op 11: sign 0, exponent 0, mantissa 0, out_operator = 11.
- Boundaries:
  - Equal exponents means shift 0.
  - Stall with both stages full deasserts in_ready until out_ready.
  - rst mid-operation discards all in-flight data.
  - Simultaneous in accept and out consume in the same cycle keeps full throughput.

Optional Feature:
FPU_ALIGN_DENORM_EN
- Defined: subnormal inputs are supported. Exponent 0 gives implicit bit 0 with effective exponent 1, and the fraction is kept. Mul exponent uses the effective exponents.
- Undefined: flush-to-zero as above. Mantissa and exponent fields are identical for all-normal inputs in both builds.

Decomposition:
- Shared package fpu_pkg:
  - op codes OP_ADD/OP_SUB/OP_MUL/OP_RSVD
  - BIAS
  - field widths EXP_W=8, FRAC_W=23, MANT_W=24, PROD_W=48
  - packed struct fpu_unpacked_t {sign, exp, mant}
- One natural combinational sub-module, fpu_unpack: field split, flush/denorm handling, zero flag. Instantiated twice in stage 1.

Test Plan:
- add 0x3F800000 + 0x3F800000, ready=1 -> 2 cycles later: sign 0, exp 0x7F, mantissa 0x000001000000, operator 00.
- sub 0x3FC00000 - 0x3FC00000 -> sign 0, exp 0x00, mantissa 0, operator 01.
- mul 0x40000000 * 0x40400000 -> sign 0, exp 0x81, mantissa 0x600000000000, operator 10.
- add 0x3F800000 + 0x30800000 (diff 30 >= MAX_SHIFT) -> exp 0x7F, mantissa 0x000000800000.
- out_ready=0, issue 3 back-to-back ops -> 2 accepted, in_ready low, outputs stable. Raise out_ready -> all 3 emerge in order, one per cycle.
- assert rst while both stages are valid -> out_valid=0 asynchronously, in_ready=1 after release, no stale result emitted.
